// File: rtl/risc_pkg.sv
// risc_pkg: shared widths, NOP encoding and loader state enum for the RISC_VI boot path
//   DATA_W_DEF    default core word width
//   OP_NOP        NOP opcode nibble; NOP_WORD_DEF is the full NOP instruction
//   ld_state_t    boot loader FSM states
package risc_pkg;

    localparam int DATA_W_DEF = 16;
    localparam logic [3:0] OP_NOP = 4'hF;
    localparam logic [15:0] NOP_WORD_DEF = {OP_NOP, 12'h000};

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_IMEM,
        S_FILL,
        S_REGS,
        S_PC,
        S_RUN,
        S_ERR
    } ld_state_t;

endpackage

// File: rtl/risc_boot_loader.sv
// risc_boot_loader: streams a program image into IMEM, register file and PC, then starts the core
//   clk, reset                 core clock, async active-high reset
//   start                      pulse to begin a (re)load from IDLE, RUN or ERR
//   s_valid/s_ready/s_data     word stream: header N, N instructions, NREGS registers, PC
//   imem_we/imem_addr/imem_wdata   registered IMEM write port
//   rf_we/rf_addr/rf_wdata         registered register-file write port
//   pc_we/pc_wdata                 registered start-PC load
//   core_reset, core_enable    core held in reset except in RUN
//   busy                       load in progress
//   err                        sticky bad-header flag
module risc_boot_loader
    import risc_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int IMEM_DEPTH = 64,
    parameter int NREGS = 8,
    parameter int CLEAR_IMEM = 1,
    parameter logic [DATA_W-1:0] NOP_WORD = DATA_W'(NOP_WORD_DEF)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic                          s_valid,
    output logic                          s_ready,
    input  logic [DATA_W-1:0]             s_data,
    output logic                          imem_we,
    output logic [$clog2(IMEM_DEPTH)-1:0] imem_addr,
    output logic [DATA_W-1:0]             imem_wdata,
    output logic                          rf_we,
    output logic [$clog2(NREGS)-1:0]      rf_addr,
    output logic [DATA_W-1:0]             rf_wdata,
    output logic                          pc_we,
    output logic [DATA_W-1:0]             pc_wdata,
    output logic                          core_reset,
    output logic                          core_enable,
    output logic                          busy,
    output logic                          err
);

    localparam int IMEM_AW = $clog2(IMEM_DEPTH);
    localparam int RF_AW = $clog2(NREGS);
    // one extra bit so the counter can hold N == IMEM_DEPTH without wrapping
    localparam int CW = IMEM_AW + 1;

    ld_state_t state, state_d;
    logic [CW-1:0] cnt, cnt_d, n, n_d;
    logic err_d, imem_we_d, rf_we_d, pc_we_d, acc, hdr_bad;
    logic [IMEM_AW-1:0] imem_addr_d;
    logic [RF_AW-1:0] rf_addr_d;
    logic [DATA_W-1:0] imem_wdata_d, rf_wdata_d, pc_wdata_d;

    // in PC, cnt marks that the PC word was taken; the extra cycle lets
    // core_enable rise one cycle after pc_we
    assign s_ready = (state inside {S_HDR, S_IMEM, S_REGS}) || (state == S_PC && cnt == '0);
    assign busy = !(state inside {S_IDLE, S_RUN, S_ERR});
    assign core_enable = state == S_RUN;
    assign core_reset = !core_enable;
    assign acc = s_valid && s_ready;
    assign hdr_bad = s_data == '0 || s_data > DATA_W'(IMEM_DEPTH);

    always_comb begin
        state_d = state;
        cnt_d = cnt;
        n_d = n;
        err_d = err;
        imem_we_d = 1'b0;
        imem_addr_d = imem_addr;
        imem_wdata_d = imem_wdata;
        rf_we_d = 1'b0;
        rf_addr_d = rf_addr;
        rf_wdata_d = rf_wdata;
        pc_we_d = 1'b0;
        pc_wdata_d = pc_wdata;
        case (state)
            S_IDLE, S_RUN, S_ERR: begin
                if (start) begin
                    state_d = S_HDR;
                    cnt_d = '0;
                    err_d = 1'b0;
                end
            end
            S_HDR: begin
                if (acc) begin
                    state_d = hdr_bad ? S_ERR : S_IMEM;
                    err_d = hdr_bad;
                    n_d = s_data[CW-1:0];
                    cnt_d = '0;
                end
            end
            S_IMEM: begin
                if (acc) begin
                    imem_we_d = 1'b1;
                    imem_addr_d = cnt[IMEM_AW-1:0];
                    imem_wdata_d = s_data;
                    cnt_d = cnt + CW'(1);
                    if (cnt + CW'(1) == n) begin
                        // on the FILL path cnt keeps running from N
                        state_d = (CLEAR_IMEM != 0 && n < CW'(IMEM_DEPTH)) ? S_FILL : S_REGS;
                        cnt_d = (CLEAR_IMEM != 0 && n < CW'(IMEM_DEPTH)) ? n : '0;
                    end
                end
            end
            S_FILL: begin
                imem_we_d = 1'b1;
                imem_addr_d = cnt[IMEM_AW-1:0];
                imem_wdata_d = NOP_WORD;
                cnt_d = (cnt == CW'(IMEM_DEPTH - 1)) ? '0 : cnt + CW'(1);
                state_d = (cnt == CW'(IMEM_DEPTH - 1)) ? S_REGS : S_FILL;
            end
            S_REGS: begin
                if (acc) begin
                    rf_we_d = 1'b1;
                    rf_addr_d = cnt[RF_AW-1:0];
                    rf_wdata_d = s_data;
                    cnt_d = (cnt == CW'(NREGS - 1)) ? '0 : cnt + CW'(1);
                    state_d = (cnt == CW'(NREGS - 1)) ? S_PC : S_REGS;
                end
            end
            S_PC: begin
                if (cnt != '0) begin
                    state_d = S_RUN;
                    cnt_d = '0;
                end else if (acc) begin
                    pc_we_d = 1'b1;
                    pc_wdata_d = s_data;
                    cnt_d = CW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
            cnt <= '0;
            n <= '0;
            err <= 1'b0;
            imem_we <= 1'b0;
            imem_addr <= '0;
            imem_wdata <= '0;
            rf_we <= 1'b0;
            rf_addr <= '0;
            rf_wdata <= '0;
            pc_we <= 1'b0;
            pc_wdata <= '0;
        end else begin
            state <= state_d;
            cnt <= cnt_d;
            n <= n_d;
            err <= err_d;
            imem_we <= imem_we_d;
            imem_addr <= imem_addr_d;
            imem_wdata <= imem_wdata_d;
            rf_we <= rf_we_d;
            rf_addr <= rf_addr_d;
            rf_wdata <= rf_wdata_d;
            pc_we <= pc_we_d;
            pc_wdata <= pc_wdata_d;
        end
    end

endmodule

// File: tb/tb_risc_boot_loader.sv
// tb_risc_boot_loader: directed scenario bench for risc_boot_loader
module tb_risc_boot_loader;

    localparam int NR = 8;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;
    logic s_valid = 1'b0;
    logic [15:0] s_data = '0;
    logic s_ready, imem_we, rf_we, pc_we, core_reset, core_enable, busy, err;
    logic [5:0] imem_addr;
    logic [2:0] rf_addr;
    logic [15:0] imem_wdata, rf_wdata, pc_wdata;

    int total = 0;
    int bad = 0;

    logic [15:0] p1 [3] = '{16'h1111, 16'h2222, 16'h3333};

    // write monitor: images of what the DUT wrote, plus ordering/timing observations
    logic [15:0] img [64];
    logic [15:0] rfi [NR];
    logic [15:0] pci = '0;
    int imem_n = 0, rf_n = 0, pc_n = 0, ord_err = 0, multi = 0, fill_cyc = 0;
    int cyc = 0, pc_cyc = 0, en_cyc = -1;
    logic clr = 1'b0;
    logic en_q = 1'b0;

    always #5 clk = ~clk;

    risc_boot_loader dut (
        .clk(clk), .reset(reset), .start(start),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .rf_we(rf_we), .rf_addr(rf_addr), .rf_wdata(rf_wdata),
        .pc_we(pc_we), .pc_wdata(pc_wdata),
        .core_reset(core_reset), .core_enable(core_enable),
        .busy(busy), .err(err)
    );

    always @(negedge clk) begin
        cyc <= cyc + 1;
        en_q <= core_enable;
        if (clr) begin
            imem_n <= 0;
            rf_n <= 0;
            pc_n <= 0;
            ord_err <= 0;
            multi <= 0;
            fill_cyc <= 0;
            en_cyc <= -1;
            pci <= 16'hDEAD;
            for (int i = 0; i < 64; i++) img[i] <= 16'hDEAD;
            for (int i = 0; i < NR; i++) rfi[i] <= 16'hDEAD;
        end else begin
            if (imem_we) begin
                img[imem_addr] <= imem_wdata;
                if (int'(imem_addr) != imem_n) ord_err <= ord_err + 1;
                imem_n <= imem_n + 1;
            end
            if (rf_we) begin
                rfi[rf_addr] <= rf_wdata;
                if (int'(rf_addr) != rf_n) ord_err <= ord_err + 1;
                rf_n <= rf_n + 1;
            end
            if (pc_we) begin
                pci <= pc_wdata;
                pc_n <= pc_n + 1;
                pc_cyc <= cyc;
            end
            if (int'(imem_we) + int'(rf_we) + int'(pc_we) > 1) multi <= multi + 1;
            // FILL cycles plus the single PC-commit cycle are the only busy, not-ready cycles
            if (busy && !s_ready) fill_cyc <= fill_cyc + 1;
            if (core_enable && !en_q) en_cyc <= cyc;
        end
    end

    task automatic clear_logs();
        clr = 1'b1;
        @(negedge clk);
        @(negedge clk);
        clr = 1'b0;
        @(negedge clk);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // present one word after `gap` idle cycles and hold it until accepted
    task automatic send(input logic [15:0] d, input int gap);
        int g;
        s_valid = 1'b0;
        repeat (gap) @(negedge clk);
        s_valid = 1'b1;
        s_data = d;
        g = 0;
        while (!s_ready && g < 200) begin
            @(negedge clk);
            g++;
        end
        total++;
        if (!s_ready) begin
            bad++;
            $display("FAIL send_timeout data=%h s_ready=%b required 1", d, s_ready);
        end
        @(negedge clk);
        s_valid = 1'b0;
    endtask

    // t1 selects the test-1 image; otherwise instr 4000+i, regs 00A0+i, PC 0010
    task automatic stream(input int n, input bit t1, input int gap, input int kick_at, input int nregs);
        send(16'(n), 0);
        for (int i = 0; i < n; i++) begin
            if (i == kick_at) pulse_start();
            send(t1 ? p1[i % 3] : 16'(16'h4000 + i), gap > 0 ? int'($urandom_range(gap, 0)) : 0);
        end
        for (int i = 0; i < nregs; i++) send(t1 ? 16'(7 - i) : 16'(16'h00A0 + i), 0);
        if (nregs == NR) send(t1 ? 16'h0000 : 16'h0010, 0);
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        #12;
        total++;
        if (core_reset !== 1'b1) begin bad++; $display("FAIL reset_core_reset got=%b exp=1", core_reset); end
        total++;
        if ({imem_we, rf_we, pc_we, core_enable, busy, err, s_ready} !== 7'b0) begin
            bad++;
            $display("FAIL reset_flags got=%b exp=0000000", {imem_we, rf_we, pc_we, core_enable, busy, err, s_ready});
        end
        total++;
        if ({imem_addr, imem_wdata, rf_addr, rf_wdata, pc_wdata} !== '0) begin
            bad++;
            $display("FAIL reset_buses got=%h exp=0", {imem_addr, imem_wdata, rf_addr, rf_wdata, pc_wdata});
        end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        clear_logs();
        pulse_start();
        stream(3, 1'b1, 0, -1, NR);
        total++;
        if (imem_n !== 64 || ord_err !== 0) begin bad++; $display("FAIL basic_imem_count got=%0d ord=%0d exp=64 ord=0", imem_n, ord_err); end
        for (int i = 0; i < 64; i++) begin
            total++;
            if (img[i] !== (i < 3 ? p1[i % 3] : 16'hF000)) begin
                bad++;
                $display("FAIL basic_imem[%0d] got=%h exp=%h", i, img[i], i < 3 ? p1[i % 3] : 16'hF000);
            end
        end
        total++;
        if (fill_cyc !== 62) begin bad++; $display("FAIL basic_fill_cycles got=%0d exp=62", fill_cyc); end
        total++;
        if (rf_n !== NR) begin bad++; $display("FAIL basic_rf_count got=%0d exp=%0d", rf_n, NR); end
        for (int i = 0; i < NR; i++) begin
            total++;
            if (rfi[i] !== 16'(7 - i)) begin bad++; $display("FAIL basic_rf[%0d] got=%h exp=%h", i, rfi[i], 16'(7 - i)); end
        end
        total++;
        if (pc_n !== 1 || pci !== 16'h0000) begin bad++; $display("FAIL basic_pc got=%h n=%0d exp=0000 n=1", pci, pc_n); end
        total++;
        if (en_cyc !== pc_cyc + 1) begin bad++; $display("FAIL basic_enable_timing got=%0d exp=%0d", en_cyc, pc_cyc + 1); end
        total++;
        if ({core_enable, core_reset, busy, s_ready, multi == 0} !== 5'b10001) begin
            bad++;
            $display("FAIL basic_run got=%b exp=10001", {core_enable, core_reset, busy, s_ready, multi == 0});
        end
    endtask

    task automatic test_hdr_err();
        clear_logs();
        pulse_start();
        send(16'd0, 0);
        total++;
        if ({err, s_ready, busy, core_reset} !== 4'b1001) begin
            bad++;
            $display("FAIL hdr_zero got=%b exp=1001", {err, s_ready, busy, core_reset});
        end
        pulse_start();
        total++;
        if ({err, s_ready} !== 2'b01) begin bad++; $display("FAIL hdr_clear1 got=%b exp=01", {err, s_ready}); end
        send(16'd65, 0);
        total++;
        if ({err, s_ready, busy} !== 3'b100) begin bad++; $display("FAIL hdr_65 got=%b exp=100", {err, s_ready, busy}); end
        repeat (2) @(negedge clk);
        total++;
        if (imem_n + rf_n + pc_n !== 0) begin bad++; $display("FAIL hdr_no_writes got=%0d exp=0", imem_n + rf_n + pc_n); end
        pulse_start();
        total++;
        if (err !== 1'b0) begin bad++; $display("FAIL hdr_clear2 got=%b exp=0", err); end
    endtask

    task automatic test_full_depth();
        clear_logs();
        pulse_start();
        stream(64, 1'b0, 2, -1, NR);
        total++;
        if (imem_n !== 64 || ord_err !== 0) begin bad++; $display("FAIL full_imem_count got=%0d ord=%0d exp=64 ord=0", imem_n, ord_err); end
        for (int i = 0; i < 64; i++) begin
            total++;
            if (img[i] !== 16'(16'h4000 + i)) begin bad++; $display("FAIL full_imem[%0d] got=%h exp=%h", i, img[i], 16'(16'h4000 + i)); end
        end
        total++;
        if (fill_cyc !== 1) begin bad++; $display("FAIL full_no_fill got=%0d exp=1", fill_cyc); end
        total++;
        if (rf_n !== NR || rfi[7] !== 16'h00A7 || pci !== 16'h0010) begin
            bad++;
            $display("FAIL full_rf_pc got=%0d/%h/%h exp=8/00a7/0010", rf_n, rfi[7], pci);
        end
        total++;
        if (core_enable !== 1'b1) begin bad++; $display("FAIL full_run got=%b exp=1", core_enable); end
    endtask

    task automatic test_restart();
        pulse_start();
        total++;
        if ({core_reset, core_enable, busy, s_ready} !== 4'b1011) begin
            bad++;
            $display("FAIL restart_state got=%b exp=1011", {core_reset, core_enable, busy, s_ready});
        end
        clear_logs();
        stream(3, 1'b1, 0, -1, NR);
        total++;
        if (imem_n !== 64 || ord_err !== 0 || fill_cyc !== 62) begin
            bad++;
            $display("FAIL restart_imem got=%0d/%0d/%0d exp=64/0/62", imem_n, ord_err, fill_cyc);
        end
        for (int i = 0; i < 4; i++) begin
            total++;
            if (img[i] !== (i < 3 ? p1[i % 3] : 16'hF000)) begin
                bad++;
                $display("FAIL restart_imem[%0d] got=%h exp=%h", i, img[i], i < 3 ? p1[i % 3] : 16'hF000);
            end
        end
        total++;
        if (rfi[0] !== 16'h0007 || pci !== 16'h0000 || core_enable !== 1'b1) begin
            bad++;
            $display("FAIL restart_done got=%h/%h/%b exp=0007/0000/1", rfi[0], pci, core_enable);
        end
    endtask

    task automatic test_reset_mid();
        clear_logs();
        pulse_start();
        stream(3, 1'b1, 0, -1, 4);
        reset = 1'b1;
        #1;
        total++;
        if ({imem_we, rf_we, pc_we, core_enable, busy, err, s_ready, core_reset} !== 8'b00000001) begin
            bad++;
            $display("FAIL midreset_flags got=%b exp=00000001", {imem_we, rf_we, pc_we, core_enable, busy, err, s_ready, core_reset});
        end
        total++;
        if ({imem_addr, imem_wdata, rf_addr, rf_wdata, pc_wdata} !== '0) begin
            bad++;
            $display("FAIL midreset_buses got=%h exp=0", {imem_addr, imem_wdata, rf_addr, rf_wdata, pc_wdata});
        end
        @(negedge clk);
        reset = 1'b0;
        clear_logs();
        pulse_start();
        stream(3, 1'b1, 0, -1, NR);
        total++;
        if (imem_n !== 64 || rf_n !== NR || pc_n !== 1 || ord_err !== 0) begin
            bad++;
            $display("FAIL midreset_reload got=%0d/%0d/%0d/%0d exp=64/8/1/0", imem_n, rf_n, pc_n, ord_err);
        end
        total++;
        if (img[2] !== 16'h3333 || img[63] !== 16'hF000 || rfi[7] !== 16'h0000 || core_enable !== 1'b1) begin
            bad++;
            $display("FAIL midreset_image got=%h/%h/%h/%b exp=3333/f000/0000/1", img[2], img[63], rfi[7], core_enable);
        end
    endtask

    task automatic test_start_ignored();
        pulse_start();
        clear_logs();
        stream(3, 1'b1, 0, 1, NR);
        total++;
        if (imem_n !== 64 || ord_err !== 0 || fill_cyc !== 62 || multi !== 0) begin
            bad++;
            $display("FAIL ignored_imem got=%0d/%0d/%0d/%0d exp=64/0/62/0", imem_n, ord_err, fill_cyc, multi);
        end
        for (int i = 0; i < 4; i++) begin
            total++;
            if (img[i] !== (i < 3 ? p1[i % 3] : 16'hF000)) begin
                bad++;
                $display("FAIL ignored_imem[%0d] got=%h exp=%h", i, img[i], i < 3 ? p1[i % 3] : 16'hF000);
            end
        end
        total++;
        if (rf_n !== NR || rfi[3] !== 16'h0004 || pci !== 16'h0000 || en_cyc !== pc_cyc + 1) begin
            bad++;
            $display("FAIL ignored_done got=%0d/%h/%h/%0d exp=8/0004/0000/%0d", rf_n, rfi[3], pci, en_cyc, pc_cyc + 1);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_hdr_err();
        test_full_depth();
        test_restart();
        test_reset_mid();
        test_start_ignored();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
